// File: rtl/vga_sync_monitor_if.sv
// Signal bundle between a VGA sync source (master) and vga_sync_monitor (slave).
interface vga_sync_monitor_if;
  // No valid/ready: hsync_in/vsync_in are level pulses sampled on every clock, and
  // every output is a registered beam/lock state that is meaningful on every cycle.
  logic       hsync_in;
  logic       vsync_in;
  logic [9:0] hpos;
  logic [9:0] vpos;
  logic       display_on;
  logic       locked;
  logic       lock_lost;
  logic [7:0] loss_count;
  logic [2:0] fsm_state;

  modport master (
    output hsync_in, vsync_in,
    input  hpos, vpos, display_on, locked, lock_lost, loss_count, fsm_state
  );

  modport slave (
    input  hsync_in, vsync_in,
    output hpos, vpos, display_on, locked, lock_lost, loss_count, fsm_state
  );
endinterface

// File: rtl/vga_sync_monitor.sv
// Recovers VGA beam position from hsync/vsync pulses and tracks timing lock.
// Optional lock-loss counter is built only when VGA_MON_STATS_EN is defined.
module vga_sync_monitor #(
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_BOTTOM  = 10,
  parameter int V_SYNC    = 2,
  parameter int V_TOP     = 33
) (
  input  logic              clk,
  input  logic              rst_n,
  vga_sync_monitor_if.slave bus
);
  localparam int H_TOTAL      = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL      = V_DISPLAY + V_BOTTOM + V_SYNC + V_TOP;
  localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
  localparam int V_SYNC_START = V_DISPLAY + V_BOTTOM;

  localparam logic [9:0] LCNT_MAX = 10'(H_TOTAL + 8);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_PRE    = 10'(V_SYNC_START - 1);

  typedef enum logic [2:0] {
    SEARCH = 3'd0,
    HMEAS  = 3'd1,
    VWAIT  = 3'd2,
    VMEAS  = 3'd3,
    LOCKED = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] hs_sr, vs_sr;
  logic       hs_edge, vs_edge;
  logic [9:0] lcnt, hpos, vpos;
  logic [9:0] vcnt_q, vcnt_d;
  logic       match_q, match_d;
  logic       lost_q, lost_d;
  logic       lcnt_sat, line_ok, hpos_wrap, frame_ok, fail;

  // [0],[1] synchronise; [2] is the delay flop used for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hs_sr <= '0;
      vs_sr <= '0;
    end else begin
      hs_sr <= {hs_sr[1:0], bus.hsync_in};
      vs_sr <= {vs_sr[1:0], bus.vsync_in};
    end
  end

  assign hs_edge   = hs_sr[1] & ~hs_sr[2];
  assign vs_edge   = vs_sr[1] & ~vs_sr[2];
  assign lcnt_sat  = (lcnt == LCNT_MAX);
  assign line_ok   = (lcnt == H_LAST);
  assign hpos_wrap = ~hs_edge & (hpos == H_LAST);
  // An hsync edge landing on the closing vsync edge belongs to the frame just measured.
  assign frame_ok  = ((vcnt_q + {9'd0, hs_edge}) == 10'(V_TOTAL));
  assign fail      = lcnt_sat | (hs_edge & ~line_ok) | (vs_edge & (vpos != V_PRE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lcnt <= '0;
      hpos <= '0;
      vpos <= '0;
    end else begin
      if (hs_edge)        lcnt <= '0;
      else if (!lcnt_sat) lcnt <= lcnt + 10'd1;

      if (hs_edge)        hpos <= 10'(H_SYNC_START);
      else if (hpos_wrap) hpos <= '0;
      else                hpos <= hpos + 10'd1;

      if (vs_edge)        vpos <= 10'(V_SYNC_START);
      else if (hpos_wrap) vpos <= (vpos == V_LAST) ? 10'd0 : vpos + 10'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEARCH;
      match_q <= 1'b0;
      vcnt_q  <= '0;
      lost_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      match_q <= match_d;
      vcnt_q  <= vcnt_d;
      lost_q  <= lost_d;
    end
  end

  always_comb begin
    state_d = state_q;
    match_d = match_q;
    vcnt_d  = vcnt_q;
    lost_d  = 1'b0;
    unique case (state_q)
      SEARCH: begin
        if (hs_edge) begin
          state_d = HMEAS;
          match_d = 1'b0;
        end
      end
      HMEAS: begin
        if (lcnt_sat) begin
          state_d = SEARCH;
        end else if (hs_edge) begin
          if (!line_ok)     match_d = 1'b0;
          else if (match_q) begin
            state_d = VWAIT;
            match_d = 1'b0;
          end else          match_d = 1'b1;
        end
      end
      VWAIT: begin
        if (lcnt_sat) begin
          state_d = SEARCH;
        end else if (vs_edge) begin
          state_d = VMEAS;
          vcnt_d  = '0;
        end
      end
      VMEAS: begin
        if (lcnt_sat) begin
          state_d = SEARCH;
        end else if (vs_edge) begin
          if (frame_ok) state_d = LOCKED;
          vcnt_d = '0;
        end else if (hs_edge && vcnt_q != 10'h3FF) begin
          vcnt_d = vcnt_q + 10'd1;
        end
      end
      LOCKED: begin
        if (fail) begin
          state_d = SEARCH;
          lost_d  = 1'b1;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

`ifdef VGA_MON_STATS_EN
  logic [7:0] loss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          loss_cnt <= '0;
    else if (lost_d && loss_cnt != 8'hFF) loss_cnt <= loss_cnt + 8'd1;
  end

  assign bus.loss_count = loss_cnt;
`else
  assign bus.loss_count = 8'd0;
`endif

  assign bus.hpos       = hpos;
  assign bus.vpos       = vpos;
  assign bus.locked     = (state_q == LOCKED);
  assign bus.display_on = bus.locked & (hpos < 10'(H_DISPLAY)) & (vpos < 10'(V_DISPLAY));
  assign bus.lock_lost  = lost_q;
  assign bus.fsm_state  = state_q;
endmodule
